// File: rtl/ysyx_22040750_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_22040750_ifu_pkg;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_NPC  = 3'd3,
        ST_DROP = 3'd4
    } ifu_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    // Sequential successor of a fetch PC; wraps modulo 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ysyx_22040750_if_id_reg.sv
// IF/ID pipeline slot: one entry with valid/ready hand-off to decode.
module ysyx_22040750_if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    input  logic        load_fault,
    input  logic        consume,
    input  logic        flush,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        fault
);

    // Flush empties the slot; a reload wins over a same-cycle consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            pc    <= 32'h0;
            inst  <= 32'h0;
            fault <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
            fault <= load_fault;
        end else if (consume) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_22040750_ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one imem read in flight,
// and hands {pc, snpc, inst} to decode through the IF/ID slot.
// Optional feature: define YSYX_22040750_IFU_ALIGN_CHK_EN to turn misaligned
// fetch addresses into a faulting NOP instead of a memory request.
module ysyx_22040750_ifu
    import ysyx_22040750_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [31:0] I_dnpc,
    input  logic        I_dnpc_valid,
    output logic        O_dnpc_ready,
    input  logic        I_flush,
    input  logic [31:0] I_flush_pc,
    output logic        O_imem_req_valid,
    input  logic        I_imem_req_ready,
    output logic [31:0] O_imem_addr,
    input  logic        I_imem_rsp_valid,
    output logic        O_imem_rsp_ready,
    input  logic [31:0] I_imem_rsp_data,
    output logic        O_IF_ID_valid,
    input  logic        I_IF_ID_ready,
    output logic [31:0] O_IF_ID_pc,
    output logic [31:0] O_IF_ID_snpc,
    output logic [31:0] O_IF_ID_inst,
    output logic        O_IF_ID_fault
);

    ifu_state_e  state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] req_addr, req_addr_next;
    logic        kill, kill_next;
    logic        slot_free;
    logic        misaligned;
    logic        ifid_load;
    logic [31:0] ifid_load_inst;
    logic        ifid_load_fault;

`ifdef YSYX_22040750_IFU_ALIGN_CHK_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign slot_free    = !O_IF_ID_valid || I_IF_ID_ready;
    assign O_imem_addr  = req_addr;
    assign O_IF_ID_snpc = next_seq_pc(O_IF_ID_pc);

    // State, fetch PC, held request address and pending-kill flag.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            kill     <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
            kill     <= kill_next;
        end
    end

    // Fetch sequencing: handshakes, redirects and the IF/ID load decision.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        req_addr_next    = req_addr;
        kill_next        = kill;
        O_imem_req_valid = 1'b0;
        O_imem_rsp_ready = 1'b0;
        O_dnpc_ready     = 1'b0;
        ifid_load        = 1'b0;
        ifid_load_inst   = I_imem_rsp_data;
        ifid_load_fault  = 1'b0;

        if (I_flush) begin
            pc_next = I_flush_pc;
        end

        case (state)
            ST_BOOT: begin
                state_next    = ST_REQ;
                req_addr_next = I_flush ? I_flush_pc : pc;
            end

            ST_REQ: begin
                if (misaligned) begin
                    // No bus traffic; redirect simply retargets the slot.
                    if (I_flush) begin
                        req_addr_next = I_flush_pc;
                    end else if (slot_free) begin
                        ifid_load       = 1'b1;
                        ifid_load_inst  = NOP_INST;
                        ifid_load_fault = 1'b1;
                        state_next      = ST_NPC;
                    end
                end else begin
                    O_imem_req_valid = 1'b1;
                    if (I_imem_req_ready) begin
                        kill_next  = 1'b0;
                        state_next = (kill || I_flush) ? ST_DROP : ST_WAIT;
                    end else if (I_flush) begin
                        kill_next = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                O_imem_rsp_ready = slot_free;
                if (I_imem_rsp_valid && slot_free) begin
                    if (I_flush) begin
                        state_next    = ST_REQ;
                        req_addr_next = I_flush_pc;
                    end else begin
                        ifid_load  = 1'b1;
                        state_next = ST_NPC;
                    end
                end else if (I_flush) begin
                    state_next = ST_DROP;
                end
            end

            ST_NPC: begin
                O_dnpc_ready = !I_flush;
                if (I_flush) begin
                    state_next    = ST_REQ;
                    req_addr_next = I_flush_pc;
                end else if (I_dnpc_valid) begin
                    pc_next       = I_dnpc;
                    req_addr_next = I_dnpc;
                    state_next    = ST_REQ;
                end
            end

            ST_DROP: begin
                O_imem_rsp_ready = 1'b1;
                if (I_imem_rsp_valid) begin
                    state_next    = ST_REQ;
                    req_addr_next = pc_next;
                end
            end

            default: begin
                state_next = ST_BOOT;
            end
        endcase
    end

    ysyx_22040750_if_id_reg u_if_id (
        .clk        (I_clk),
        .rst_n      (I_rst_n),
        .load       (ifid_load),
        .load_pc    (req_addr),
        .load_inst  (ifid_load_inst),
        .load_fault (ifid_load_fault),
        .consume    (I_IF_ID_ready),
        .flush      (I_flush),
        .valid      (O_IF_ID_valid),
        .pc         (O_IF_ID_pc),
        .inst       (O_IF_ID_inst),
        .fault      (O_IF_ID_fault)
    );

endmodule

// File: tb/tb_ysyx_22040750_ifu.sv
// Bench for ysyx_22040750_ifu: directed scenarios plus a randomized run
// against a transaction-level model of the fetch stream.
module tb_ysyx_22040750_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dnpc;
    logic        dnpc_valid;
    logic        dnpc_ready;
    logic        flush;
    logic [31:0] flush_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] imem_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_snpc;
    logic [31:0] ifid_inst;
    logic        ifid_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22040750_ifu dut (
        .I_clk            (clk),
        .I_rst_n          (rst_n),
        .I_dnpc           (dnpc),
        .I_dnpc_valid     (dnpc_valid),
        .O_dnpc_ready     (dnpc_ready),
        .I_flush          (flush),
        .I_flush_pc       (flush_pc),
        .O_imem_req_valid (req_valid),
        .I_imem_req_ready (req_ready),
        .O_imem_addr      (imem_addr),
        .I_imem_rsp_valid (rsp_valid),
        .O_imem_rsp_ready (rsp_ready),
        .I_imem_rsp_data  (rsp_data),
        .O_IF_ID_valid    (ifid_valid),
        .I_IF_ID_ready    (ifid_ready),
        .O_IF_ID_pc       (ifid_pc),
        .O_IF_ID_snpc     (ifid_snpc),
        .O_IF_ID_inst     (ifid_inst),
        .O_IF_ID_fault    (ifid_fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, a[31:16] ^ 16'h0f0f};
    endfunction

    task automatic idle_inputs();
        dnpc       = 32'h0;
        dnpc_valid = 1'b0;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = 32'h0;
        ifid_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) tick();
        settle();
        total++; if (req_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_req_valid got=%b want=0", req_valid); end
        total++; if (rsp_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_rsp_ready got=%b want=0", rsp_ready); end
        total++; if (dnpc_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_dnpc_ready got=%b want=0", dnpc_ready); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_ifid_valid got=%b want=0", ifid_valid); end
        total++; if (ifid_pc !== 32'h0 || ifid_inst !== 32'h0 || ifid_fault !== 1'b0) begin bad++; $display("[TB] FAIL rst_ifid_fields got=%h/%h/%b want=0/0/0", ifid_pc, ifid_inst, ifid_fault); end
        total++; if (imem_addr !== RST_PC) begin bad++; $display("[TB] FAIL rst_addr got=%h want=%h", imem_addr, RST_PC); end
        rst_n = 1'b1;
        settle();
        total++; if (req_valid !== 1'b0) begin bad++; $display("[TB] FAIL boot_req_valid got=%b want=0", req_valid); end
        tick();
        settle();
        total++; if (req_valid !== 1'b1 || imem_addr !== RST_PC) begin bad++; $display("[TB] FAIL first_req got=%b/%h want=1/%h", req_valid, imem_addr, RST_PC); end
    endtask

    task automatic test_first_fetch();
        req_ready = 1'b1;
        settle();
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_0293;
        settle();
        total++; if (rsp_ready !== 1'b1) begin bad++; $display("[TB] FAIL wait_rsp_ready got=%b want=1", rsp_ready); end
        tick();
        rsp_valid = 1'b0;
        settle();
        total++; if (ifid_valid !== 1'b1) begin bad++; $display("[TB] FAIL first_ifid_valid got=%b want=1", ifid_valid); end
        total++; if (ifid_pc !== 32'h8000_0000) begin bad++; $display("[TB] FAIL first_ifid_pc got=%h want=80000000", ifid_pc); end
        total++; if (ifid_snpc !== 32'h8000_0004) begin bad++; $display("[TB] FAIL first_ifid_snpc got=%h want=80000004", ifid_snpc); end
        total++; if (ifid_inst !== 32'h0000_0293) begin bad++; $display("[TB] FAIL first_ifid_inst got=%h want=00000293", ifid_inst); end
        total++; if (dnpc_ready !== 1'b1 || req_valid !== 1'b0 || ifid_fault !== 1'b0) begin bad++; $display("[TB] FAIL npc_outputs got=%b/%b/%b want=1/0/0", dnpc_ready, req_valid, ifid_fault); end
    endtask

    task automatic test_dnpc();
        dnpc       = 32'h8000_0010;
        dnpc_valid = 1'b1;
        ifid_ready = 1'b0;
        settle();
        tick();
        dnpc_valid = 1'b0;
        settle();
        total++; if (req_valid !== 1'b1 || imem_addr !== 32'h8000_0010) begin bad++; $display("[TB] FAIL dnpc_req got=%b/%h want=1/80000010", req_valid, imem_addr); end
        total++; if (ifid_valid !== 1'b1 || dnpc_ready !== 1'b0) begin bad++; $display("[TB] FAIL dnpc_hold_entry got=%b/%b want=1/0", ifid_valid, dnpc_ready); end
    endtask

    task automatic test_flush_wait();
        req_ready = 1'b1;
        settle();
        tick();
        req_ready = 1'b0;
        flush     = 1'b1;
        flush_pc  = 32'h8000_0100;
        settle();
        tick();
        flush = 1'b0;
        settle();
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_wait_ifid got=%b want=0", ifid_valid); end
        total++; if (req_valid !== 1'b0 || rsp_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_wait_drop got=%b/%b want=0/1", req_valid, rsp_ready); end
        rsp_valid = 1'b1;
        rsp_data  = 32'hdead_beef;
        settle();
        tick();
        rsp_valid = 1'b0;
        settle();
        total++; if (req_valid !== 1'b1 || imem_addr !== 32'h8000_0100) begin bad++; $display("[TB] FAIL flush_wait_req got=%b/%h want=1/80000100", req_valid, imem_addr); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_wait_dropped got=%b want=0", ifid_valid); end
        req_ready = 1'b1;
        settle();
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = mem_word(32'h8000_0100);
        settle();
        tick();
        rsp_valid = 1'b0;
        settle();
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8000_0100 || ifid_inst !== mem_word(32'h8000_0100)) begin bad++; $display("[TB] FAIL flush_wait_refetch got=%b/%h/%h want=1/80000100/%h", ifid_valid, ifid_pc, ifid_inst, mem_word(32'h8000_0100)); end
    endtask

    task automatic test_flush_req_stall();
        dnpc       = 32'h8000_0200;
        dnpc_valid = 1'b1;
        ifid_ready = 1'b1;
        settle();
        tick();
        dnpc_valid = 1'b0;
        ifid_ready = 1'b0;
        flush      = 1'b1;
        flush_pc   = 32'h8000_0100;
        settle();
        total++; if (req_valid !== 1'b1 || imem_addr !== 32'h8000_0200) begin bad++; $display("[TB] FAIL stall_flush_cycle got=%b/%h want=1/80000200", req_valid, imem_addr); end
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++; if (req_valid !== 1'b1 || imem_addr !== 32'h8000_0200) begin bad++; $display("[TB] FAIL stall_hold_%0d got=%b/%h want=1/80000200", i, req_valid, imem_addr); end
            tick();
        end
        req_ready = 1'b1;
        settle();
        tick();
        req_ready = 1'b0;
        settle();
        total++; if (req_valid !== 1'b0 || rsp_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_drop got=%b/%b want=0/1", req_valid, rsp_ready); end
        rsp_valid = 1'b1;
        rsp_data  = 32'h0bad_0bad;
        settle();
        tick();
        rsp_valid = 1'b0;
        settle();
        total++; if (req_valid !== 1'b1 || imem_addr !== 32'h8000_0100 || ifid_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_redirect got=%b/%h/%b want=1/80000100/0", req_valid, imem_addr, ifid_valid); end
        req_ready = 1'b1;
        settle();
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = mem_word(32'h8000_0100);
        settle();
        tick();
        rsp_valid = 1'b0;
        settle();
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8000_0100) begin bad++; $display("[TB] FAIL stall_refetch got=%b/%h want=1/80000100", ifid_valid, ifid_pc); end
    endtask

    task automatic test_decode_stall();
        dnpc       = 32'h8000_0104;
        dnpc_valid = 1'b1;
        ifid_ready = 1'b0;
        settle();
        tick();
        dnpc_valid = 1'b0;
        req_ready  = 1'b1;
        settle();
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h0040_0093;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++; if (rsp_ready !== 1'b0) begin bad++; $display("[TB] FAIL dstall_rsp_ready_%0d got=%b want=0", i, rsp_ready); end
            total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8000_0100) begin bad++; $display("[TB] FAIL dstall_keep_%0d got=%b/%h want=1/80000100", i, ifid_valid, ifid_pc); end
            tick();
        end
        ifid_ready = 1'b1;
        settle();
        total++; if (rsp_ready !== 1'b1) begin bad++; $display("[TB] FAIL dstall_free got=%b want=1", rsp_ready); end
        tick();
        rsp_valid  = 1'b0;
        ifid_ready = 1'b0;
        settle();
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8000_0104 || ifid_inst !== 32'h0040_0093 || dnpc_ready !== 1'b1) begin bad++; $display("[TB] FAIL dstall_reload got=%b/%h/%h/%b want=1/80000104/00400093/1", ifid_valid, ifid_pc, ifid_inst, dnpc_ready); end
    endtask

    task automatic test_snpc_wrap();
        dnpc       = 32'hffff_fffc;
        dnpc_valid = 1'b1;
        ifid_ready = 1'b1;
        settle();
        tick();
        dnpc_valid = 1'b0;
        ifid_ready = 1'b0;
        req_ready  = 1'b1;
        settle();
        total++; if (imem_addr !== 32'hffff_fffc) begin bad++; $display("[TB] FAIL wrap_addr got=%h want=fffffffc", imem_addr); end
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h0000_0073;
        settle();
        tick();
        rsp_valid = 1'b0;
        settle();
        total++; if (ifid_pc !== 32'hffff_fffc || ifid_snpc !== 32'h0) begin bad++; $display("[TB] FAIL wrap_snpc got=%h/%h want=fffffffc/00000000", ifid_pc, ifid_snpc); end
    endtask

`ifdef YSYX_22040750_IFU_ALIGN_CHK_EN
    task automatic test_misaligned();
        dnpc       = 32'h8000_0002;
        dnpc_valid = 1'b1;
        ifid_ready = 1'b1;
        settle();
        tick();
        dnpc_valid = 1'b0;
        ifid_ready = 1'b0;
        settle();
        total++; if (req_valid !== 1'b0) begin bad++; $display("[TB] FAIL misalign_no_req got=%b want=0", req_valid); end
        tick();
        settle();
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h8000_0002) begin bad++; $display("[TB] FAIL misalign_entry got=%b/%h want=1/80000002", ifid_valid, ifid_pc); end
        total++; if (ifid_inst !== 32'h0000_0013 || ifid_fault !== 1'b1) begin bad++; $display("[TB] FAIL misalign_fault got=%h/%b want=00000013/1", ifid_inst, ifid_fault); end
        total++; if (req_valid !== 1'b0 || dnpc_ready !== 1'b1) begin bad++; $display("[TB] FAIL misalign_npc got=%b/%b want=0/1", req_valid, dnpc_ready); end
    endtask
`endif

    task automatic test_async_reset();
        dnpc       = 32'h8000_0020;
        dnpc_valid = 1'b1;
        ifid_ready = 1'b1;
        settle();
        tick();
        dnpc_valid = 1'b0;
        ifid_ready = 1'b0;
        req_ready  = 1'b1;
        settle();
        tick();
        req_ready = 1'b0;
        settle();
        total++; if (rsp_ready !== 1'b1) begin bad++; $display("[TB] FAIL areset_pre got=%b want=1", rsp_ready); end
        rst_n = 1'b0;
        #1;
        total++; if (rsp_ready !== 1'b0 || req_valid !== 1'b0 || ifid_valid !== 1'b0 || imem_addr !== RST_PC) begin bad++; $display("[TB] FAIL areset_now got=%b/%b/%b/%h want=0/0/0/%h", rsp_ready, req_valid, ifid_valid, imem_addr, RST_PC); end
    endtask

    task automatic test_random();
        logic [31:0] exp_fetch;
        bit          exp_fetch_ok;
        bit          ghost;
        logic [31:0] ghost_addr;
        bit          outstanding;
        bit          out_stale;
        logic [31:0] out_addr;
        int          lat;
        logic [31:0] dq[$];
        bit          awaiting;
        logic [31:0] npc_choice;
        int          delivered;
        bit          s_req_valid, s_rsp_ready, s_dnpc_ready, s_ifid_valid;
        logic [31:0] s_addr, s_pc, s_snpc, s_inst;

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n        = 1'b1;
        exp_fetch    = RST_PC;
        exp_fetch_ok = 1'b1;
        ghost        = 1'b0;
        ghost_addr   = 32'h0;
        outstanding  = 1'b0;
        out_stale    = 1'b0;
        out_addr     = 32'h0;
        lat          = 0;
        awaiting     = 1'b0;
        npc_choice   = 32'h0;
        delivered    = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            req_ready  = ($urandom_range(0, 3) != 0);
            rsp_valid  = outstanding && (lat == 0);
            rsp_data   = mem_word(out_addr);
            if (outstanding && lat > 0) lat--;
            ifid_ready = ($urandom_range(0, 2) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            flush_pc   = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
            dnpc_valid = awaiting && ($urandom_range(0, 2) != 0);
            dnpc       = npc_choice;
            settle();

            s_req_valid  = req_valid;
            s_rsp_ready  = rsp_ready;
            s_dnpc_ready = dnpc_ready;
            s_ifid_valid = ifid_valid;
            s_addr       = imem_addr;
            s_pc         = ifid_pc;
            s_snpc       = ifid_snpc;
            s_inst       = ifid_inst;

            total++; if (s_ifid_valid !== (dq.size() != 0)) begin bad++; $display("[TB] FAIL rnd_ifid_valid cyc=%0d got=%b want=%b", cyc, s_ifid_valid, dq.size() != 0); end
            total++; if (s_dnpc_ready !== (awaiting && !flush)) begin bad++; $display("[TB] FAIL rnd_dnpc_ready cyc=%0d got=%b want=%b", cyc, s_dnpc_ready, awaiting && !flush); end
            if (s_req_valid) begin
                total++; if (outstanding || !(ghost || exp_fetch_ok)) begin bad++; $display("[TB] FAIL rnd_req_allowed cyc=%0d got=1 want=0", cyc); end
            end

            if (s_ifid_valid && ifid_ready && dq.size() != 0) begin
                total++; if (s_pc !== dq[0] || s_inst !== mem_word(dq[0]) || s_snpc !== dq[0] + 32'd4) begin bad++; $display("[TB] FAIL rnd_entry cyc=%0d got=%h/%h/%h want=%h/%h/%h", cyc, s_pc, s_inst, s_snpc, dq[0], mem_word(dq[0]), dq[0] + 32'd4); end
                void'(dq.pop_front());
            end

            if (rsp_valid && s_rsp_ready) begin
                outstanding = 1'b0;
                if (!out_stale && !flush) begin
                    dq.push_back(out_addr);
                    awaiting   = 1'b1;
                    npc_choice = ($urandom_range(0, 1) == 0) ? out_addr + 32'd4
                                 : (32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2));
                    delivered++;
                end
            end

            if (s_req_valid && req_ready) begin
                if (ghost) begin
                    total++; if (s_addr !== ghost_addr) begin bad++; $display("[TB] FAIL rnd_killed_addr cyc=%0d got=%h want=%h", cyc, s_addr, ghost_addr); end
                    ghost     = 1'b0;
                    out_stale = 1'b1;
                end else begin
                    total++; if (s_addr !== exp_fetch) begin bad++; $display("[TB] FAIL rnd_fetch_addr cyc=%0d got=%h want=%h", cyc, s_addr, exp_fetch); end
                    exp_fetch_ok = 1'b0;
                    out_stale    = 1'b0;
                end
                outstanding = 1'b1;
                out_addr    = s_addr;
                lat         = $urandom_range(0, 3);
            end

            if (dnpc_valid && s_dnpc_ready) begin
                exp_fetch    = dnpc;
                exp_fetch_ok = 1'b1;
                awaiting     = 1'b0;
            end

            if (flush) begin
                if (s_req_valid && !req_ready) begin
                    ghost      = 1'b1;
                    ghost_addr = s_addr;
                end
                if (outstanding) out_stale = 1'b1;
                dq.delete();
                awaiting     = 1'b0;
                exp_fetch    = flush_pc;
                exp_fetch_ok = 1'b1;
            end

            tick();
        end
        idle_inputs();
        total++; if (delivered < 100) begin bad++; $display("[TB] FAIL rnd_progress got=%0d want>=100", delivered); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_dnpc();
        test_flush_wait();
        test_flush_req_stall();
        test_decode_stall();
        test_snpc_wrap();
`ifdef YSYX_22040750_IFU_ALIGN_CHK_EN
        test_misaligned();
`endif
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
